// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link: default widths, FIFO depth,
// flow-control thresholds and the link parity function.
package interboard_pkg;

    localparam int IB_DATA_W     = 11;
    localparam int IB_USEDW_W    = 8;
    localparam int IB_FIFO_DEPTH = 256;
    localparam int IB_STOP_LVL   = 252;
    localparam int IB_START_LVL  = 251;

    // Even parity over {ch, data}.
    // The arguments are wide and zero-extended, so the zero padding does not
    // change the result.
    function automatic logic ib_parity(input logic [31:0] ch, input logic [63:0] data);
        return (^ch) ^ (^data);
    endfunction

endpackage

// File: rtl/rx_flow_hyst.sv
// Per-channel hysteretic "may send" line.
// It drops at or above STOP_LVL and rises again at or below START_LVL.
module rx_flow_hyst
    import interboard_pkg::*;
#(
    parameter int USEDW_W   = IB_USEDW_W,
    parameter int STOP_LVL  = IB_STOP_LVL,
    parameter int START_LVL = IB_START_LVL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [USEDW_W-1:0] usedw,
    output logic               read
);

    localparam logic [USEDW_W:0] STOP_L  = (USEDW_W+1)'(STOP_LVL);
    localparam logic [USEDW_W:0] START_L = (USEDW_W+1)'(START_LVL);

    logic read_q;
    logic read_d;

    // Next value: stop wins, then start, otherwise hold inside the band.
    always_comb begin
        read_d = read_q;
        if ({1'b0, usedw} >= STOP_L) begin
            read_d = 1'b0;
        end else if ({1'b0, usedw} <= START_L) begin
            read_d = 1'b1;
        end
    end

    // State register; the line stays low while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= 1'b0;
        end else begin
            read_q <= read_d;
        end
    end

    assign read = read_q;

endmodule

// File: rtl/interboard_rx_vc.sv
// Multi-channel inter-board receiver.
// Steering: each incoming word is checked for parity and steered to its
// channel FIFO.
// Drops: a word that cannot be delivered is counted and raises a sticky flag.
// Flow control: the per-channel read lines follow each FIFO's fill level.
//
// Input handshake: the interface is valid-only, with no ready.
// - A word is presented when valid=1 and is consumed on that same edge.
// - The block never stalls: back-pressure reaches the sender only through
//   read[i], which the sender may overrun by its pipeline depth.
// - Words beyond the FIFO's capacity are dropped.
module interboard_rx_vc
    import interboard_pkg::*;
#(
    parameter int DATA_W     = IB_DATA_W,
    parameter int NUM_CH     = 2,
    parameter int USEDW_W    = IB_USEDW_W,
    parameter int FIFO_DEPTH = IB_FIFO_DEPTH,
    parameter int STOP_LVL   = IB_STOP_LVL,
    parameter int START_LVL  = IB_START_LVL,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      transmit_clk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [CH_W-1:0]           receive_ch,
    input  logic [DATA_W-1:0]         receive_data,
    input  logic                      receive_par,
    input  logic [NUM_CH*USEDW_W-1:0] wrusedw,
    input  logic                      err_clear,
    output logic [DATA_W-1:0]         data,
    output logic [NUM_CH-1:0]         wrreq,
    output logic [NUM_CH-1:0]         read,
    output logic                      parity_err,
    output logic [NUM_CH-1:0]         overflow,
    output logic                      bad_ch,
    output logic [15:0]               drop_count
);

    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [USEDW_W:0] FULL_LVL = (USEDW_W+1)'(FIFO_DEPTH - 1);

    logic [DATA_W-1:0]  data_q;
    logic [NUM_CH-1:0]  wrreq_q, wrreq_d;
    logic               parity_err_q, parity_err_d;
    logic               bad_ch_q, bad_ch_d;
    logic [NUM_CH-1:0]  overflow_q, overflow_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic [15:0]        cnt_base;

    logic               par_ok;
    logic               ch_ok;
    logic               full;
    logic               accept;
    logic               drop;
    logic [USEDW_W-1:0] usedw_sel;
    logic [NUM_CH-1:0]  ch_onehot;

    // Decode the word.
    // Drop precedence is parity, then tag, then fullness, so exactly one
    // flag is raised per dropped word.
    // A clear that coincides with a drop lets the new drop survive.
    always_comb begin
        usedw_sel = '0;
        ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (receive_ch == CH_W'(i)) begin
                usedw_sel    = wrusedw[i*USEDW_W +: USEDW_W];
                ch_onehot[i] = 1'b1;
            end
        end

        par_ok = (ib_parity(32'(receive_ch), 64'(receive_data)) == receive_par);
        ch_ok  = ({1'b0, receive_ch} < NUM_CH_L);
        full   = ({1'b0, usedw_sel} >= FULL_LVL);
        accept = valid && par_ok && ch_ok && !full;
        drop   = valid && !accept;

        wrreq_d = accept ? ch_onehot : '0;

        parity_err_d = (err_clear ? 1'b0 : parity_err_q) | (valid && !par_ok);
        bad_ch_d     = (err_clear ? 1'b0 : bad_ch_q) | (valid && par_ok && !ch_ok);
        overflow_d   = (err_clear ? '0 : overflow_q)
                     | ((valid && par_ok && ch_ok && full) ? ch_onehot : '0);

        cnt_base     = err_clear ? 16'd0 : drop_count_q;
        drop_count_d = (drop && (cnt_base != 16'hFFFF)) ? cnt_base + 16'd1 : cnt_base;
    end

    // Output, flag and counter registers.
    // The word sampled during reset is discarded.
    always_ff @(posedge transmit_clk) begin
        if (reset) begin
            data_q       <= '0;
            wrreq_q      <= '0;
            parity_err_q <= 1'b0;
            bad_ch_q     <= 1'b0;
            overflow_q   <= '0;
            drop_count_q <= '0;
        end else begin
            data_q       <= receive_data;
            wrreq_q      <= wrreq_d;
            parity_err_q <= parity_err_d;
            bad_ch_q     <= bad_ch_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // One hysteretic flow-control line per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rx_flow_hyst #(
            .USEDW_W   (USEDW_W),
            .STOP_LVL  (STOP_LVL),
            .START_LVL (START_LVL)
        ) u_hyst (
            .clk   (transmit_clk),
            .reset (reset),
            .usedw (wrusedw[g*USEDW_W +: USEDW_W]),
            .read  (read[g])
        );
    end

    assign data       = data_q;
    assign wrreq      = wrreq_q;
    assign parity_err = parity_err_q;
    assign bad_ch     = bad_ch_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_interboard_rx_vc.sv
// Bench for interboard_rx_vc with three channels, so that an out-of-range
// tag (3) can be driven.
// The bench runs directed steps followed by a random stream, all checked
// against a rule-level reference model.
module tb_interboard_rx_vc;
    import interboard_pkg::*;

    localparam int NCH = 3;
    localparam int CHW = 2;
    localparam int DW  = IB_DATA_W;
    localparam int UW  = IB_USEDW_W;

    logic                  transmit_clk = 1'b0;
    logic                  reset;
    logic                  valid;
    logic [CHW-1:0]        receive_ch;
    logic [DW-1:0]         receive_data;
    logic                  receive_par;
    logic [NCH*UW-1:0]     wrusedw;
    logic                  err_clear;
    logic [DW-1:0]         data;
    logic [NCH-1:0]        wrreq;
    logic [NCH-1:0]        read;
    logic                  parity_err;
    logic [NCH-1:0]        overflow;
    logic                  bad_ch;
    logic [15:0]           drop_count;

    interboard_rx_vc #(.NUM_CH(NCH)) dut (
        .transmit_clk (transmit_clk),
        .reset        (reset),
        .valid        (valid),
        .receive_ch   (receive_ch),
        .receive_data (receive_data),
        .receive_par  (receive_par),
        .wrusedw      (wrusedw),
        .err_clear    (err_clear),
        .data         (data),
        .wrreq        (wrreq),
        .read         (read),
        .parity_err   (parity_err),
        .overflow     (overflow),
        .bad_ch       (bad_ch),
        .drop_count   (drop_count)
    );

    // Clock and reset block.
    always #5 transmit_clk = ~transmit_clk;

    int total = 0;
    int bad   = 0;

    // Fill levels driven on the next cycle.
    int u [NCH];

    // Reference model state.
    int m_data;
    int m_wrreq;
    bit m_read [NCH];
    bit m_par;
    bit m_badch;
    bit m_ovf [NCH];
    int m_cnt;

    function automatic bit even_par(input int ch, input int d);
        return bit'(($countones(ch & 3) + $countones(d & 'h7FF)) % 2);
    endfunction

    task automatic model_reset();
        m_data  = 0;
        m_wrreq = 0;
        m_par   = 0;
        m_badch = 0;
        m_cnt   = 0;
        for (int i = 0; i < NCH; i++) begin
            m_read[i] = 0;
            m_ovf[i]  = 0;
        end
    endtask

    // Reference model: applies the receiver's rules to one sampled word.
    task automatic model_step(input bit v, input int ch, input int d, input bit par, input bit clr);
        bit good;
        bit acc;
        good    = (even_par(ch, d) == par);
        acc     = v && good && (ch < NCH) && (u[ch] < IB_FIFO_DEPTH - 1);
        m_data  = d;
        m_wrreq = acc ? (1 << ch) : 0;
        if (clr) begin
            m_par   = 0;
            m_badch = 0;
            m_cnt   = 0;
            for (int i = 0; i < NCH; i++) m_ovf[i] = 0;
        end
        if (v && !acc) begin
            if (!good)           m_par     = 1;
            else if (ch >= NCH)  m_badch   = 1;
            else                 m_ovf[ch] = 1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (u[i] >= IB_STOP_LVL)       m_read[i] = 0;
            else if (u[i] <= IB_START_LVL) m_read[i] = 1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] er;
        logic [NCH-1:0] eo;
        for (int i = 0; i < NCH; i++) begin
            er[i] = m_read[i];
            eo[i] = m_ovf[i];
        end
        check_val({tag, ".data"},       32'(data),       32'(m_data));
        check_val({tag, ".wrreq"},      32'(wrreq),      32'(m_wrreq));
        check_val({tag, ".read"},       32'(read),       32'(er));
        check_val({tag, ".parity_err"}, 32'(parity_err), 32'(m_par));
        check_val({tag, ".overflow"},   32'(overflow),   32'(eo));
        check_val({tag, ".bad_ch"},     32'(bad_ch),     32'(m_badch));
        check_val({tag, ".drop_count"}, 32'(drop_count), 32'(m_cnt));
    endtask

    task automatic pack_usedw();
        for (int i = 0; i < NCH; i++) wrusedw[i*UW +: UW] = u[i][UW-1:0];
    endtask

    // Driver: presents one word (optionally with bad parity), steps one edge,
    // then checks all outputs against the model.
    task automatic cycle(input string tag, input bit v, input int ch, input int d,
                         input bit par_good, input bit clr);
        bit p;
        @(negedge transmit_clk);
        p            = even_par(ch, d) ^ !par_good;
        reset        = 1'b0;
        valid        = v;
        receive_ch   = ch[CHW-1:0];
        receive_data = d[DW-1:0];
        receive_par  = p;
        err_clear    = clr;
        pack_usedw();
        @(posedge transmit_clk);
        model_step(v, ch, d, p, clr);
        #1;
        check_all(tag);
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge transmit_clk);
        reset        = 1'b1;
        valid        = 1'b1;
        receive_ch   = CHW'($urandom_range(0, 3));
        receive_data = DW'($urandom);
        receive_par  = 1'($urandom);
        err_clear    = 1'b0;
        pack_usedw();
        @(posedge transmit_clk);
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset        = 1'b1;
        valid        = 1'b0;
        receive_ch   = '0;
        receive_data = '0;
        receive_par  = 1'b0;
        err_clear    = 1'b0;
        for (int i = 0; i < NCH; i++) u[i] = 0;
        pack_usedw();
        model_reset();

        // Reset held for three cycles with valid words present.
        for (int k = 0; k < 3; k++) reset_cycle("reset");
        check_val("reset.read_low", 32'(read), 32'd0);

        // First evaluation after release with empty FIFOs.
        cycle("release", 0, 0, 0, 1, 0);
        check_val("release.read_all", 32'(read), 32'b111);

        // A single good word.
        cycle("single", 1, 1, 'h5A3, 1, 0);
        check_val("single.wrreq", 32'(wrreq), 32'b010);
        check_val("single.data", 32'(data), 32'h5A3);

        // A parity error, then clear it.
        cycle("parity", 1, 0, 'h001, 0, 0);
        check_val("parity.flag", 32'(parity_err), 32'd1);
        check_val("parity.count", 32'(drop_count), 32'd1);
        cycle("clear", 0, 0, 0, 1, 1);
        check_val("clear.count", 32'(drop_count), 32'd0);

        // Sweep channel 0 through the hysteresis band.
        u[0] = 250; cycle("hyst_up250", 0, 0, 0, 1, 0);
        u[0] = 251; cycle("hyst_up251", 0, 0, 0, 1, 0);
        check_val("hyst.up251", 32'(read[0]), 32'd1);
        u[0] = 252; cycle("hyst_up252", 0, 0, 0, 1, 0);
        check_val("hyst.up252", 32'(read[0]), 32'd0);
        u[0] = 253; cycle("hyst_up253", 0, 0, 0, 1, 0);
        u[0] = 252; cycle("hyst_dn252", 0, 0, 0, 1, 0);
        check_val("hyst.dn252", 32'(read[0]), 32'd0);
        u[0] = 251; cycle("hyst_dn251", 0, 0, 0, 1, 0);
        check_val("hyst.dn251", 32'(read[0]), 32'd1);
        u[0] = 250; cycle("hyst_dn250", 0, 0, 0, 1, 0);

        // Channel 1 full: its word is dropped; the next ch0 word still writes.
        u[1] = 255;
        cycle("ovf", 1, 1, 'h2AA, 1, 0);
        check_val("ovf.flag", 32'(overflow), 32'b010);
        check_val("ovf.wrreq", 32'(wrreq), 32'd0);
        cycle("ovf_ch0", 1, 0, 'h155, 1, 0);
        check_val("ovf_ch0.wrreq", 32'(wrreq), 32'b001);
        // Level 254 is still below the full bound, so the word is accepted.
        u[1] = 254;
        cycle("edge254", 1, 1, 'h0F0, 1, 0);
        check_val("edge254.wrreq", 32'(wrreq), 32'b010);
        u[1] = 0;

        // Out-of-range tag.
        cycle("badtag", 1, 3, 'h3C3, 1, 0);
        check_val("badtag.flag", 32'(bad_ch), 32'd1);

        // Bad parity on tag 3: parity takes precedence over the tag check.
        cycle("clear2", 0, 0, 0, 1, 1);
        cycle("prec", 1, 3, 'h011, 0, 0);
        check_val("prec.bad_ch", 32'(bad_ch), 32'd0);

        // Random stream, with a reset in the middle.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < NCH; i++)
                u[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(245, 255) : $urandom_range(0, 255);
            if (k == 1000) begin
                reset_cycle("rand_reset");
            end else begin
                cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                      $urandom_range(0, 2047), $urandom_range(0, 9) != 0,
                      $urandom_range(0, 19) == 0);
            end
        end

        // Saturate the drop counter with bad-parity words.
        for (int i = 0; i < NCH; i++) u[i] = 0;
        cycle("sat_clear", 0, 0, 0, 1, 1);
        for (int k = 0; k < 65540; k++) cycle("sat", 1, k % NCH, k & 'h7FF, 0, 0);
        check_val("sat.count", 32'(drop_count), 32'hFFFF);

        // A clear together with a drop leaves the count at one.
        cycle("clr_drop", 1, 0, 'h007, 0, 1);
        check_val("clr_drop.count", 32'(drop_count), 32'd1);
        check_val("clr_drop.par", 32'(parity_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interboard_rx_vc.md
# interboard_rx_vc

Parametrised multi-channel receiver for inter-board links, running in the sending board's `transmit_clk` domain. It accepts tagged words from an upstream board's output stage and checks parity. It steers each word to one of `NUM_CH` per-channel receive FIFOs. For each channel it drives a hysteretic `read` flow-control line back to the sender, based on that FIFO's fill level. Words that cannot be delivered are dropped and counted. Each drop raises a sticky error.

## Interface
- `DATA_W`, 11: payload width.
- `NUM_CH`, 2: channel count, ≥1; `CH_W = max(1,$clog2(NUM_CH))` is derived.
- `USEDW_W`, 8: width of each FIFO fill-level input.
- `FIFO_DEPTH`, 256: words per channel FIFO, ≤ 2^USEDW_W.
- `STOP_LVL`, 252: `read` is deasserted when usedw ≥ this; must be < `FIFO_DEPTH`−1.
- `START_LVL`, 251: `read` is asserted when usedw ≤ this; must be < `STOP_LVL`.
- `transmit_clk` in 1: clock, from the sending board.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: `receive_*` are valid this cycle.
- `receive_ch` in CH_W: channel tag.
- `receive_data` in DATA_W: payload.
- `receive_par` in 1: even parity over {`receive_ch`, `receive_data`}.
- `wrusedw` in NUM_CH*USEDW_W: per-channel FIFO fill level; channel i is at [i*USEDW_W +: USEDW_W].
- `err_clear` in 1: clears the sticky errors.
- `data` out DATA_W: shared write data to all channel FIFOs.
- `wrreq` out NUM_CH: one-hot per-channel write request.
- `read` out NUM_CH: per-channel "may send" to the sender.
- `parity_err` out 1: sticky, set on any parity failure.
- `overflow` out NUM_CH: sticky, set per channel when a word is dropped because that FIFO is full.
- `bad_ch` out 1: sticky, set when a word arrives with tag ≥ `NUM_CH`.
- `drop_count` out 16: count of dropped words, saturating at 0xFFFF.

## Operation
- **Reset values:** `data`=0, `wrreq`=0, `read`=0, `parity_err`=0, `overflow`=0, `bad_ch`=0, `drop_count`=0.
- **Input sampling:** every cycle, the inputs are sampled on the `transmit_clk` edge.
  - `data` ← `receive_data` unconditionally.
- **Accept condition:** a word is accepted when all of the following hold:
  - `valid`=1;
  - parity is good (the XOR of ch, data and par is 0);
  - `receive_ch` < `NUM_CH`;
  - usedw[ch] < `FIFO_DEPTH`−1.
- **Accepted word:** `wrreq` ← one-hot(`receive_ch`).
- **Otherwise:** `wrreq` ← 0.
- **Drop causes:** a word with `valid`=1 that is not accepted is a drop. Flags are set as follows:
  - `parity_err` on bad parity;
  - `bad_ch` on an out-of-range tag;
  - `overflow[ch]` on a full FIFO with good parity and an in-range tag.
- **Drop precedence:** parity is checked first, then tag, then fullness.
  - Only one flag is set per word.
  - `drop_count` increments by exactly 1 per drop, and stops at 0xFFFF.
- **Error clearing:** `err_clear`=1 clears all sticky flags and `drop_count`.
  - If a drop occurs in the same cycle, the new drop wins: its flag is set and `drop_count`=1.
- **Flow control:** per channel i, independently:
  - usedw ≥ `STOP_LVL` → `read[i]`←0;
  - else usedw ≤ `START_LVL` → `read[i]`←1;
  - else `read[i]` holds its value.
- **Sender overrun:** the sender may over-run `read`=0 by its pipeline depth. The `STOP_LVL` margin absorbs this; beyond the margin, words are dropped and `overflow` is flagged.

## Timing
- **Data path:** latency is 1 cycle, from `valid`/`receive_*` at edge n to `data`/`wrreq` valid after edge n. There is no stall or back-pressure inside the block.
- **Flag and counter updates:** `read`, the sticky flags and `drop_count` all update on the same edge as the sampled word or `wrusedw`.
- **Back-to-back words:** accepted every cycle, on any mix of channels.
- **Full check:** uses `wrusedw` as sampled at the same edge. It does not account for the write issued one cycle earlier. The FIFO is therefore required to report usedw including the prior-cycle write, or to tolerate it via the `FIFO_DEPTH`−1 bound.
- **Reset mid-stream:** the word sampled during reset is discarded. `read` stays 0 until the first post-reset evaluation.

## Structure
- **Package `interboard_pkg`:** default `DATA_W`, `USEDW_W`, `FIFO_DEPTH`, `STOP_LVL` and `START_LVL`, plus the parity function `ib_parity(ch, data)`. This package is shared with the output-side block.
- **Sub-module `rx_flow_hyst`:** one instance per channel, generated in a loop. Ports: clk, reset, usedw and `read` out; it is parametrised by `STOP_LVL` and `START_LVL`.
- **Top level:** the top holds the decode, drop logic, flags and counter.

## Test plan
- **Reset:** hold reset 3 cycles with `valid`=1 → all outputs 0, and `read`=0 on both channels; one cycle after release, with usedw=0, `read`=2'b11.
- **Single word:** ch=1, data=0x5A3, good parity → next cycle `wrreq`=2'b10 and `data`=0x5A3; `drop_count`=0.
- **Parity error:** ch=0, data=0x001, par=0 → `wrreq`=0, `parity_err`=1, `drop_count`=1; `err_clear` then returns both to 0.
- **Hysteresis:** sweep usedw[0] up 250→253 → `read[0]` drops when usedw=252. Sweep back 253→250 → `read[0]` stays 0 at 252, and returns to 1 at 251.
- **Overflow:** usedw[1]=255 with a valid ch=1 word → `overflow`=2'b10 and `wrreq`=0. A concurrent ch=0 word is still written on the next cycle.
- **Bad tag and saturation:** with `NUM_CH`=3, tag 3 → `bad_ch`=1. Then 65 540 consecutive bad-parity words → `drop_count`=0xFFFF. `err_clear` in the same cycle as a drop → `drop_count`=1.
